// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder with four 32-bit control registers, byte strobes and per-register write pulses.
// Optional build macro: AXI_LITE_REG_SLVERR_EN (unmapped accesses answer SLVERR instead of OKAY).
module axi_lite_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NSTB = DW / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  // Handshake rule on every channel: a transfer happens on the rising edge where valid and ready are both high.
  logic            r_aw_held;
  logic            r_w_held;
  logic [AW-1:2]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [NSTB-1:0] r_wstrb;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic            r_rvalid;
  logic [1:0]      r_rresp;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_regs [4];
  logic [3:0]      r_wr_pulse;

  logic       w_awready, w_wready, w_arready;
  logic       w_aw_hs, w_w_hs, w_ar_hs;
  logic       w_commit;
  logic       w_wr_mapped, w_rd_mapped;
  logic [1:0] w_wr_idx, w_rd_idx;
  logic       w_unused;

  assign w_awready = ~r_aw_held & ~r_bvalid;
  assign w_wready  = ~r_w_held & ~r_bvalid;
  assign w_arready = ~r_rvalid;

  assign w_aw_hs = s00_axi_awvalid & w_awready;
  assign w_w_hs  = s00_axi_wvalid & w_wready;
  assign w_ar_hs = s00_axi_arvalid & w_arready;

  assign w_commit    = r_aw_held & r_w_held;
  assign w_wr_idx    = r_awaddr[3:2];
  assign w_wr_mapped = (r_awaddr[AW-1:4] == '0);
  assign w_rd_idx    = s00_axi_araddr[3:2];
  assign w_rd_mapped = (s00_axi_araddr[AW-1:4] == '0);

  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write side: AW and W are captured independently; the edge after both are held commits them.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s00_axi_awaddr[AW-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s00_axi_wdata;
        r_wstrb  <= s00_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
        if (w_wr_mapped) begin
          for (int k = 0; k < NSTB; k++) begin
            if (r_wstrb[k]) r_regs[w_wr_idx][8*k +: 8] <= r_wdata[8*k +: 8];
          end
          r_wr_pulse[w_wr_idx] <= 1'b1;
        end
      end else if (r_bvalid && s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read side samples the registers before any same-edge commit lands, so it returns the old value.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
      r_rdata  <= w_rd_mapped ? r_regs[w_rd_idx] : '0;
    end else if (r_rvalid && s00_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < 4; i++) reg_out[i*DW +: DW] = r_regs[i];
  end

  assign s00_axi_awready = w_awready;
  assign s00_axi_wready  = w_wready;
  assign s00_axi_arready = w_arready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rdata;
  assign reg_wr_pulse    = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Scoreboard bench for axi_lite_reg_responder: directed scenarios plus randomized traffic against a register-array model.
module tb_axi_lite_reg_responder;

`ifdef AXI_LITE_REG_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, arvalid;
  logic        bready = 1'b0;
  logic        rready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] reg_out;
  logic [3:0]  reg_wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [31:0] m_regs[4];
  int exp_pulse[4];
  int obs_pulse[4];
  int b_mode = 2;
  int r_mode = 2;

  axi_lite_reg_responder dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  // clock / reset-independent infrastructure
  initial forever #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [127:0] model_pack();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic logic pick_ready(input int m);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // response-channel ready generator
  initial forever begin
    @(posedge clk);
    #1;
    bready = pick_ready(b_mode);
    rready = pick_ready(r_mode);
  end

  // scoreboard monitor
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bvalid && bready) begin
          if (exp_b_q.size() == 0) note_fail("unexpected_bresp");
          else begin
            eb = exp_b_q.pop_front();
            check("bresp", 128'(bresp), 128'(eb));
          end
        end
        if (rvalid && rready) begin
          if (exp_r_q.size() == 0) note_fail("unexpected_rresp");
          else begin
            er = exp_r_q.pop_front();
            check("rresp_rdata", 128'({rresp, rdata}), 128'(er));
          end
        end
        for (int k = 0; k < 4; k++) if (reg_wr_pulse[k]) obs_pulse[k]++;
      end
    end
  end

  // driver tasks: all start and end at posedge+1
  task automatic drive_aw(input logic [5:0] a, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      n++;
      if (n > 100) begin note_fail("aw_timeout"); break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (wready) break;
      n++;
      if (n > 100) begin note_fail("w_timeout"); break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [5:0] a);
    int n;
    araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      n++;
      if (n > 100) begin note_fail("ar_timeout"); break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      n++;
      if (n > 100) begin note_fail("b_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    forever begin
      @(negedge clk);
      if (rvalid && rready) break;
      n++;
      if (n > 100) begin note_fail("r_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin note_fail("idle_timeout"); break; end
    end
  endtask

  // Reference model: AXI-Lite register file with byte strobes; unmapped accesses touch nothing.
  task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[5:4] == 2'b00) begin
      for (int k = 0; k < 4; k++) if (s[k]) m_regs[a[3:2]][8*k +: 8] = d[8*k +: 8];
      exp_pulse[a[3:2]]++;
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(UNMAP_RESP);
    end
  endtask

  task automatic model_read(input logic [5:0] a);
    if (a[5:4] == 2'b00) exp_r_q.push_back({2'b00, m_regs[a[3:2]]});
    else exp_r_q.push_back({UNMAP_RESP, 32'h0});
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_d, input int w_d);
    model_write(a, d, s);
    fork
      drive_aw(a, aw_d);
      drive_w(d, s, w_d);
    join
    wait_b();
    @(negedge clk);
    check("reg_out_after_write", reg_out, model_pack());
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] a);
    model_read(a);
    drive_ar(a);
    wait_r();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
  endtask

  // main stimulus
  initial begin
    logic [5:0]   ra;
    logic [127:0] snap;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_awready", 128'(awready), 128'(1'b1));
    check("reset_wready", 128'(wready), 128'(1'b1));
    check("reset_arready", 128'(arready), 128'(1'b1));
    check("reset_bvalid", 128'(bvalid), 128'(1'b0));
    check("reset_rvalid", 128'(rvalid), 128'(1'b0));
    check("reset_reg_out", reg_out, 128'(0));
    check("reset_pulse", 128'(reg_wr_pulse), 128'(0));
    @(posedge clk); #1;

    // basic write then read of all four registers
    for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF, i % 2, (i + 1) % 3);
    for (int i = 0; i < 4; i++) axi_read(6'(4 * i));
    check("reg_out_1234", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
    for (int k = 0; k < 4; k++) check($sformatf("pulse_once_%0d", k), 128'(obs_pulse[k]), 128'(1));

    // byte strobes
    axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(6'h04, 32'h1234_5678, 4'b0101, 1, 0);
    check("strobe_reg1", 128'(reg_out[63:32]), 128'(32'hFF34_FF78));
    axi_read(6'h04);

    // W first, AW three cycles later, bready held low
    b_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    model_write(6'h00, 32'h55AA_55AA, 4'hF);
    wdata = 32'h55AA_55AA; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); check("w_first_wready", 128'(wready), 128'(1'b1));
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk); check("w_first_wready_drop", 128'(wready), 128'(1'b0));
    repeat (2) begin @(posedge clk); #1; end
    awaddr = 6'h00; awvalid = 1'b1;
    @(negedge clk); check("late_aw_awready", 128'(awready), 128'(1'b1));
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); check("no_commit_before_edge4", 128'(bvalid), 128'(1'b0));
    @(negedge clk);
    check("commit_bvalid", 128'(bvalid), 128'(1'b1));
    check("commit_reg0", 128'(reg_out[31:0]), 128'(32'h55AA_55AA));
    check("commit_pulse", 128'(reg_wr_pulse), 128'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bhold_state", 128'({bvalid, awready, wready, reg_wr_pulse}), 128'({3'b100, 4'b0000}));
    end
    b_mode = 2;
    wait_idle();

    // unmapped access
    snap = model_pack();
    axi_write(6'h20, 32'h0000_DEAD, 4'hF, 0, 1);
    axi_read(6'h20);
    check("unmapped_regs_unchanged", reg_out, snap);

    // write commit and read of the same register on one edge
    model_read(6'h08);
    model_write(6'h08, 32'h0000_00AA, 4'hF);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h0000_00AA; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); check("same_edge_aw_w_ready", 128'({awready, wready}), 128'(2'b11));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge clk); check("same_edge_arready", 128'(arready), 128'(1'b1));
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk); check("same_edge_reg2_new", 128'(reg_out[95:64]), 128'(32'hAA));
    @(posedge clk); #1;
    wait_idle();
    axi_read(6'h08);

    // randomized traffic
    b_mode = 0; r_mode = 0;
    for (int i = 0; i < 40; i++) begin
      ra = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ra[5:4] = 2'b00;
      if ($urandom_range(0, 1) == 1)
        axi_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(ra);
    end
    wait_idle();

    // reset with an AW held and a read response pending
    b_mode = 1; r_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    drive_ar(6'h00);
    drive_aw(6'h08, 0);
    @(negedge clk);
    check("pre_reset_rvalid_awheld", 128'({rvalid, awready}), 128'(2'b10));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    b_mode = 2; r_mode = 2;
    @(negedge clk);
    check("rst2_valids", 128'({bvalid, rvalid}), 128'(2'b00));
    check("rst2_readies", 128'({awready, wready, arready}), 128'(3'b111));
    check("rst2_reg_out", reg_out, 128'(0));
    check("rst2_rdata_rresp", 128'({rresp, rdata}), 128'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("rst2_no_response", 128'({bvalid, rvalid}), 128'(2'b00));
    end
    @(posedge clk); #1;
    drive_w(32'h0BAD_F00D, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("rst2_aw_dropped", 128'(bvalid), 128'(1'b0));
    end
    @(posedge clk); #1;
    model_write(6'h04, 32'h0BAD_F00D, 4'hF);
    drive_aw(6'h04, 0);
    wait_b();
    @(negedge clk); check("rst2_write_after", reg_out, model_pack());
    @(posedge clk); #1;
    axi_read(6'h04);
    wait_idle();

    for (int k = 0; k < 4; k++) check($sformatf("pulse_total_%0d", k), 128'(obs_pulse[k]), 128'(exp_pulse[k]));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_responder.md
# axi_lite_reg_responder

AXI4-Lite slave (responder) exposing four 32-bit read/write control registers to a PS or VIP master; it is the register-side endpoint that the sampling IP's bus master drives. It accepts write address and write data in any order, applies byte strobes, returns one write response and one read response per transaction, and exports register contents plus per-register write pulses to the sampling fabric.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; registers occupy 0x00–0x0C, and 0x10–0x3C is unmapped.
- s00_axi_aclk  in  1  sole clock; all logic on rising edge.
- s00_axi_areset  in  1  reset, synchronous, active-high.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  6/3/1/1  write address channel; awprot ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  6/3/1/1  read address channel; arprot ignored.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- reg_out  out  128  {reg3,reg2,reg1,reg0} current contents.
- reg_wr_pulse  out  4  one-cycle strobe per register on commit.

## Operation
- Register index = addr[3:2]; addr[1:0] ignored; addr[5:4]≠0 is unmapped.
- Write side keeps two flags, aw_held and w_held, each with a latched payload.
- awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
- A handshake (valid & ready) sets the corresponding flag and latches its payload.
- Commit edge: the first edge with aw_held & w_held.
  - Each byte lane k with wstrb[k]=1 is written.
  - Both flags clear, bvalid←1, bresp←OKAY (2'b00).
  - reg_wr_pulse[idx]←1 for exactly one cycle.
- bvalid holds until bready; its clearing edge reopens awready/wready for the next cycle. One write is outstanding at a time.
- Read: arready = ~rvalid. On an AR handshake, rdata←reg[idx], rresp←OKAY, rvalid←1. rdata/rresp/rvalid stay stable until rready.
- Read and write channels are fully independent and can complete on the same edge.
- Reset clears reg0–reg3, both flags, bvalid, rvalid, rdata, bresp, rresp and reg_wr_pulse to 0, and drives awready/wready/arready to 1 in the following cycle. A transaction in flight at reset is dropped with no response.

## Timing
- Write commit occurs one edge after the later of the AW/W handshakes.
  - AW and W handshake together at edge E: commit, register update and bvalid=1 at E+1; reg_wr_pulse high for cycle E+1..E+2.
  - AW at E and W at E+3: commit at E+4.
- Earliest next awready after a bready handshake at edge F: cycle following F.
- Read latency: rvalid is high the cycle after the AR handshake edge; with rready tied high, throughput is one read every 2 cycles.
- A read handshaking on the same edge as a write commit to the same register returns the pre-write value.
- reg_out reflects new contents from the commit edge onward.

## Configuration
- AXI_LITE_REG_SLVERR_EN defined:
  - Unmapped write: no register change, no pulse, bresp=SLVERR (2'b10).
  - Unmapped read: rdata=0, rresp=SLVERR.
- AXI_LITE_REG_SLVERR_EN undefined:
  - Unmapped write is silently dropped with bresp=OKAY.
  - Unmapped read returns rdata=0 with rresp=OKAY.
- Handshake timing is identical in both builds.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read the same addresses → rdata 0x1..0x4 with all responses OKAY; reg_wr_pulse bits 0..3 each fire once.
- Preload reg1=0xFFFFFFFF, then write 0x12345678 with wstrb=4'b0101 → reg1 reads 0xFF34FF78.
- Drive W at cycle 0 and AW at cycle 3 → wready drops after cycle 0, commit at edge 4, bvalid high from edge 4; with bready held low 5 cycles, bvalid, awready=0 and wready=0 stay unchanged.
- Write 0xDEAD to 0x20 and read 0x20:
  - With macro: bresp=2'b10, rresp=2'b10, rdata=0.
  - Without macro: OKAY, rdata=0.
  - In both builds reg0–reg3 are unchanged.
- Write 0xAA to reg2 committing on the same edge as a read of reg2 (old 0x3) → read returns 0x3; the next read returns 0xAA.
- Assert reset while aw_held=1 and rvalid=1 → next cycle bvalid=rvalid=0, all registers 0, all readies 1, and no response is issued.
